// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine datapath
// (controller, timer and product selector).
package vending_pkg;

    localparam int CREDIT_W = 5;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 5'd31;

    localparam logic [1:0] PRODUCT_NONE = 2'd0;
    localparam logic [1:0] PRODUCT_A    = 2'd1;
    localparam logic [1:0] PRODUCT_B    = 2'd2;
    localparam logic [1:0] PRODUCT_C    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_PAY      = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4,
        ST_RELEASE  = 3'd5
    } state_t;

endpackage

// File: rtl/vending_timer.sv
// Reloadable inactivity down-counter; expired is high while the count reads 0.
module vending_timer #(
    parameter int TIMEOUT_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/vending_controller.sv
// Transaction sequencer: selection request, coin collection, dispense/change
// and selector release. Every output is a register loaded on state entry.
module vending_controller
    import vending_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cancel,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                product_selector_done,
    input  logic [CREDIT_W-1:0] product_price,
    input  logic [1:0]          product_out,
    output logic                product_selector_en,
    output logic                timeout_flag,
    output logic                dispense_valid,
    output logic [1:0]          dispense_id,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                coin_reject,
    output logic                busy,
    output state_t              debug_state
);

    // All strobes are single-cycle with no back-pressure: a *_valid pulse
    // qualifies its data bus for that cycle only; coin_value is taken only
    // while coin_valid is high, product_price/product_out only with done.
    state_t state, state_next;
    logic [CREDIT_W-1:0] credit, credit_next, price, price_next;
    logic [1:0] prod, prod_next;
    logic timer_clear, timer_load, timer_enable, timer_expired;

    logic sel_en_d, timeout_d, disp_valid_d, change_valid_d, coin_reject_d;
    logic [1:0] disp_id_d;
    logic [CREDIT_W-1:0] change_amount_d, credit_post, remainder;
    logic [CREDIT_W:0] coin_sum;
    logic coin_accepted;

    vending_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .load    (timer_load),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
    assign remainder = (credit >= price) ? (credit - price) : '0;

    always_comb begin
        state_next      = state;
        credit_next     = credit;
        price_next      = price;
        prod_next       = prod;
        timer_clear     = 1'b0;
        timer_load      = 1'b0;
        timer_enable    = 1'b0;
        sel_en_d        = 1'b0;
        timeout_d       = 1'b0;
        disp_valid_d    = 1'b0;
        disp_id_d       = PRODUCT_NONE;
        change_valid_d  = 1'b0;
        change_amount_d = '0;
        coin_reject_d   = coin_valid;
        credit_post     = credit;
        coin_accepted   = 1'b0;
        case (state)
            ST_IDLE: begin
                credit_next = '0;
                if (start) begin
                    state_next = ST_SELECT;
                    timer_load = 1'b1;
                    sel_en_d   = 1'b1;
                end else begin
                    timer_clear = 1'b1;
                end
            end
            ST_SELECT: begin
                timer_enable = 1'b1;
                if (product_selector_done && (product_out != PRODUCT_NONE)) begin
                    price_next = product_price;
                    prod_next  = product_out;
                    timer_load = 1'b1;
                    state_next = ST_PAY;
                end else if (product_selector_done || timer_expired) begin
                    state_next = ST_RELEASE;
                    timeout_d  = 1'b1;
                end
            end
            ST_PAY: begin
                timer_enable = 1'b1;
                if (coin_valid && (coin_sum <= {1'b0, CREDIT_MAX})) begin
                    credit_post   = coin_sum[CREDIT_W-1:0];
                    coin_accepted = 1'b1;
                    coin_reject_d = 1'b0;
                    timer_load    = 1'b1;
                end
                credit_next = credit_post;
                // Cancel wins over paid-up; a coin this cycle defers expiry.
                if (cancel || ((credit_post < price) && timer_expired && !coin_accepted)) begin
                    state_next      = ST_RELEASE;
                    timeout_d       = 1'b1;
                    change_valid_d  = (credit_post != '0);
                    change_amount_d = credit_post;
                    credit_next     = '0;
                end else if (credit_post >= price) begin
                    state_next   = ST_DISPENSE;
                    disp_valid_d = 1'b1;
                    disp_id_d    = prod;
                end
            end
            ST_DISPENSE: begin
                credit_next = remainder;
                if (remainder != '0) begin
                    state_next      = ST_CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = remainder;
                end else begin
                    state_next = ST_RELEASE;
                    timeout_d  = 1'b1;
                end
            end
            ST_CHANGE: begin
                credit_next = '0;
                state_next  = ST_RELEASE;
                timeout_d   = 1'b1;
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ST_IDLE;
            credit              <= '0;
            price               <= '0;
            prod                <= PRODUCT_NONE;
            product_selector_en <= 1'b0;
            timeout_flag        <= 1'b0;
            dispense_valid      <= 1'b0;
            dispense_id         <= PRODUCT_NONE;
            change_valid        <= 1'b0;
            change_amount       <= '0;
            coin_reject         <= 1'b0;
            busy                <= 1'b0;
        end else begin
            state               <= state_next;
            credit              <= credit_next;
            price               <= price_next;
            prod                <= prod_next;
            product_selector_en <= sel_en_d;
            timeout_flag        <= timeout_d;
            dispense_valid      <= disp_valid_d;
            dispense_id         <= disp_id_d;
            change_valid        <= change_valid_d;
            change_amount       <= change_amount_d;
            coin_reject         <= coin_reject_d;
            busy                <= (state_next != ST_IDLE);
        end
    end

    assign debug_state = state;

endmodule

// File: doc/vending_controller.md
# vending_controller

Top-level sequencer for the vending machine datapath. It accepts a customer start request and pulses `product_selector_en` to latch a selection in the product selector. It then collects coins against the returned `product_price`, runs the inactivity timer, and issues dispense and change pulses. It drives the selector's `timeout_flag` to release the selection whenever a transaction ends.

## Interface
- `TIMEOUT_CYCLES`, default 20: inactivity limit in clk cycles for the SELECT and PAY states; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, **asynchronous, active-high**.
- `start` in 1: customer select request; level sampled in IDLE only.
- `cancel` in 1: customer abort; honoured in PAY only.
- `coin_valid` in 1: one-cycle coin strobe.
- `coin_value` in 5: coin value in credit units; valid with `coin_valid`.
- `product_selector_done` in 1: selector finished a selection.
- `product_price` in 5: selector price; sampled when done is high.
- `product_out` in 2: selector product ID; 2'b00 means invalid.
- `product_selector_en` out 1: one-cycle selection request to the selector.
- `timeout_flag` out 1: one-cycle release pulse to the selector.
- `dispense_valid` out 1: one-cycle dispense strobe.
- `dispense_id` out 2: product ID; valid with `dispense_valid`.
- `change_valid` out 1: one-cycle refund/change strobe.
- `change_amount` out 5: refund amount; valid with `change_valid`.
- `coin_reject` out 1: one-cycle pulse, the cycle after a coin is rejected.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE
  - SELECT
  - PAY
  - DISPENSE
  - CHANGE
  - RELEASE
- Registers: `credit` (5 b), `price` (5 b), `prod` (2 b), timer.
- IDLE:
  - `start`=1 → SELECT.
  - Pulse `product_selector_en` in the first SELECT cycle.
  - Clear the timer and `credit`.
- SELECT:
  - On `product_selector_done` with `product_out`≠0: latch `price` and `prod`, go to PAY, reload the timer.
  - On `product_selector_done` with `product_out`=0: go to RELEASE.
  - Timer expiry without done: go to RELEASE.
- PAY, evaluated in this order each cycle:
  1. Coin: if `credit`+`coin_value` > 31, reject the coin. Otherwise add it to `credit` and reload the timer.
  2. `cancel`: refund the full `credit`, including a coin accepted this cycle, then go to RELEASE. Cancel beats a paid-up condition in the same cycle.
  3. Paid: if `credit` (post-add) ≥ `price`, go to DISPENSE.
  4. Timer expiry: refund `credit` and go to RELEASE. A coin accepted in the same cycle reloads the timer and prevents the expiry.
- DISPENSE:
  - Assert `dispense_valid`, `dispense_id`=`prod`.
  - `credit` ← `credit`−`price` (never negative).
  - Nonzero remainder → CHANGE; zero remainder → RELEASE.
- CHANGE: assert `change_valid`, `change_amount`=`credit`, clear `credit`, go to RELEASE.
- Refund on cancel/timeout: `change_valid` is asserted in the RELEASE cycle only when `credit`≠0.
- RELEASE: assert `timeout_flag` for one cycle, then go to IDLE.
- Coins outside PAY are always rejected via `coin_reject`.
- `cancel` outside PAY is ignored.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `credit`, `price`, `prod`, timer all 0.
- All outputs are registered from state and registers; there is no combinational input→output path.
- `start` to `product_selector_en`: 1 cycle.
- Paid-up coin edge to `dispense_valid`: 1 cycle.
- `dispense_valid` to `change_valid`: 1 cycle.
- `timeout_flag` follows the last transaction pulse by 1 cycle.
- Timer expiry: it is reloaded to `TIMEOUT_CYCLES`−1 on entry or coin and decrements each cycle. Expiry is the cycle it reads 0. Exactly `TIMEOUT_CYCLES` idle cycles elapse with no coin.
- Reset mid-transaction: return to IDLE immediately. No refund is issued, and credit is lost by design.
- Minimum transaction: IDLE→SELECT→PAY→DISPENSE→RELEASE→IDLE.

## Structure
- `vending_pkg` holds:
  - The state enum.
  - `CREDIT_W`=5.
  - Product codes `PRODUCT_NONE`/`PRODUCT_A`/`PRODUCT_B`/`PRODUCT_C` = 0..3.
  - `CREDIT_MAX`=31.
  - These are shared with the product selector.
- One sub-module, `vending_timer`: a reloadable down-counter with load, enable and expired outputs, parameterised by `TIMEOUT_CYCLES`.
- The FSM and credit arithmetic live in `vending_controller`.

## Test plan
- Exact payment:
  - Stimulus: `start`; selector returns `product_out`=01, price 10; two coins of 5.
  - Response: `dispense_valid` with id 01 one cycle after the 2nd coin, no `change_valid`, then a `timeout_flag` pulse, `busy` falls.
- Overpay:
  - Stimulus: price 15; coins 10 then 10.
  - Response: `dispense_valid`, next cycle `change_valid` with `change_amount`=5, then `timeout_flag`.
- Invalid selection:
  - Stimulus: `product_out`=00 with done.
  - Response: straight to `timeout_flag`, no dispense or change.
- Timeout in PAY:
  - Stimulus: price 20, one coin of 7, then `TIMEOUT_CYCLES` idle cycles.
  - Response: `change_valid` with 7 together with `timeout_flag`.
  - Negative check: one coin at cycle `TIMEOUT_CYCLES`−1 delays the expiry.
- Cancel, saturation and reject:
  - Saturation stimulus: credit 30, then a coin of 5.
  - Saturation response: `coin_reject`, credit stays 30.
  - Cancel stimulus: `cancel` together with a coin of 1.
  - Cancel response: refund 31.
  - Out-of-PAY stimulus: a coin in IDLE.
  - Out-of-PAY response: `coin_reject`.
- Reset mid-PAY:
  - Stimulus: assert `rst` asynchronously with credit 12.
  - Response: all outputs 0 immediately, state IDLE, no refund after release.
